dbus_initiator: RTL and testbench
=================================

DBUS_INITIATOR -- requirements
Module: dbus_initiator

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: maximum WAIT-state cycles before an error response; 0 disables the watchdog.
REQ-002 SHALL have port clk_i, input, 1: the only clock.
REQ-003 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-004 SHALL have port req_valid_i / req_ready_o, in/out, 1/1: pipeline request handshake.
REQ-005 SHALL have port req_we_i, req_lr_i, req_sc_i, req_unsigned_i, in, 1 each: store / load-reserved / store-conditional / zero-extend load.
REQ-006 SHALL have port req_size_i, in, 2: 00 byte, 01 half, 10 word; 11 is illegal and handled as word.
REQ-007 SHALL have port req_addr_i / req_wdata_i, in, 32/32: byte address / store data (LSB-aligned).
REQ-008 SHALL have port resp_valid_o, resp_err_o, out, 1/1: one-cycle response pulse and error flag.
REQ-009 SHALL have port resp_rdata_o, out, 32: extended load data, or raw SC result word.
REQ-010 SHALL have port dbus_re_o, dbus_we_o, dbus_is_lr_o, dbus_is_sc_o, out, 1 each: bus request controls.
REQ-011 SHALL have port dbus_addr_o, dbus_wdata_o, dbus_wstrb_o, out, 32/32/4: word-aligned address, lane-shifted data, byte strobes.
REQ-012 SHALL have port dbus_rdata_i / dbus_stall_i, in, 32/1: response data / busy from the dbus responder.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-014 req_ready_o SHALL be 1 only in IDLE; a request is accepted in the cycle req_valid_i && req_ready_o, and its fields are registered.
REQ-015 SHALL drive all dbus_*_o outputs from registers, nonzero for exactly the one ISSUE cycle and all-zero in every other state.
REQ-016 dbus_addr_o SHALL be {req_addr[31:2],2'b00}; a request with word address 0 SHALL NOT be issued; it completes in RESP with resp_err_o=1.
REQ-017 SHALL set wstrb byte=4'b0001<<a[1:0], half=4'b0011<<a[1:0], word=4'b1111, and wdata = replicated byte/half shifted to lane a[1:0]; loads SHALL drive wstrb=0.
REQ-018 SHALL ignore dbus_stall_i in ISSUE; in WAIT, dbus_stall_i=0 completes the access and dbus_rdata_i is captured in that same cycle.
REQ-019 Load data SHALL be the lane selected by a[1:0], then sign-extended (req_unsigned_i=0) or zero-extended; for SC, dbus_rdata_i SHALL pass unmodified (0=success, 1=fail).
REQ-020 RESP SHALL last one cycle with resp_valid_o=1, then return to IDLE; back-to-back requests are therefore at most one per 4 cycles.
REQ-021 With TIMEOUT_CYCLES>0, a counter (cleared on entering WAIT) reaching TIMEOUT_CYCLES with stall still high SHALL force RESP with resp_err_o=1, resp_rdata_o=0.
REQ-022 req_lr_i with req_we_i=1, or req_sc_i with req_we_i=0, SHALL be rejected as error without bus issue.

Reset
REQ-023 While rst_ni=0: state IDLE, all outputs 0 except req_ready_o=0; req_ready_o SHALL rise in the first cycle after deassertion.
REQ-024 Reset mid-transaction SHALL abandon the access with no response; dbus outputs drop to 0 immediately.

Configuration
REQ-025 Macro DBUS_MISALIGN_TRAP_EN defined: a half at a[0]=1 or a word at a[1:0]!=0 SHALL give resp_err_o=1 without bus issue. Undefined: the offending low address bits SHALL be cleared and the access proceeds normally.

Structure
REQ-026 Package dbus_pkg SHALL hold the FSM state encoding, the size encodings (SZ_BYTE/SZ_HALF/SZ_WORD), and the SC success/fail constants.
REQ-027 Sub-module dbus_lane_align SHALL be combinational store lane-shift/strobe generation and load extract/extend, shared with future initiators.

Verification
REQ-028 Word load 0x100, stall high 3 cycles, rdata 0xDEADBEEF -> single ISSUE pulse re=1 addr=0x100; resp_rdata_o=0xDEADBEEF one cycle after stall falls.
REQ-029 Byte store 0xA5 to 0x203 -> addr=0x200, wstrb=4'b1000, wdata=0xA5A5A5A5, we=1; response err=0.
REQ-030 Signed byte load 0x102 with rdata 0x0080_0000 -> resp_rdata_o=0xFFFFFF80; unsigned gives 0x00000080.
REQ-031 LR 0x300, then SC 0x300 with rdata=0 -> dbus_is_lr_o then dbus_is_sc_o pulses; SC resp_rdata_o=0.
REQ-032 TIMEOUT_CYCLES=4, stall held high -> resp_err_o=1 after 4 WAIT cycles; access to 0x0 -> error, no dbus activity.
REQ-033 Half load at 0x101, with and without DBUS_MISALIGN_TRAP_EN -> error without issue vs. issue at 0x100 with lane 0.

Source files
------------

// File: rtl/dbus_pkg.sv
// Shared types and constants for dbus initiators: FSM states, access sizes,
// and store-conditional result codes.
package dbus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic [31:0] SC_SUCCESS = 32'd0;
  localparam logic [31:0] SC_FAIL    = 32'd1;

  // The reserved size code 2'b11 behaves as a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == 2'b11) ? SZ_WORD : sz;
  endfunction

endpackage

// File: rtl/dbus_lane_align.sv
// Combinational byte-lane steering: store replication/strobes and
// load lane extraction with sign or zero extension.
module dbus_lane_align
  import dbus_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  input  logic        unsigned_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] rdata_o
);

  logic [31:0] lane;

  always_comb begin
    lane = rdata_i >> {lo_i, 3'b000};
    case (size_i)
      SZ_BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        wstrb_o = 4'b0001 << lo_i;
        rdata_o = {{24{lane[7] & ~unsigned_i}}, lane[7:0]};
      end
      SZ_HALF: begin
        wdata_o = {2{wdata_i[15:0]}};
        wstrb_o = 4'b0011 << lo_i;
        rdata_o = {{16{lane[15] & ~unsigned_i}}, lane[15:0]};
      end
      default: begin
        wdata_o = wdata_i;
        wstrb_o = 4'b1111;
        rdata_o = lane;
      end
    endcase
  end

endmodule

// File: rtl/dbus_initiator.sv
// Single-outstanding dbus initiator: IDLE -> ISSUE -> WAIT -> RESP.
// Define DBUS_MISALIGN_TRAP_EN to reject misaligned half/word accesses.
module dbus_initiator
  import dbus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic        req_lr_i,
  input  logic        req_sc_i,
  input  logic        req_unsigned_i,
  input  logic [1:0]  req_size_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic        resp_err_o,
  output logic [31:0] resp_rdata_o,
  output logic        dbus_re_o,
  output logic        dbus_we_o,
  output logic        dbus_is_lr_o,
  output logic        dbus_is_sc_o,
  output logic [31:0] dbus_addr_o,
  output logic [31:0] dbus_wdata_o,
  output logic [3:0]  dbus_wstrb_o,
  input  logic [31:0] dbus_rdata_i,
  input  logic        dbus_stall_i
);

  state_e      state_q;
  logic        ready_q, resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        re_q, we_q, lr_q, sc_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;
  logic        acc_we_q, acc_sc_q, acc_uns_q;
  logic [1:0]  acc_size_q, acc_lo_q;
  logic [31:0] cnt_q;

  logic [1:0]  acc_size_d, acc_lo_d;
  logic        reject_d;
  logic [1:0]  al_size, al_lo;
  logic [31:0] al_wdata, al_rdata;
  logic [3:0]  al_wstrb;

  always_comb begin
    acc_size_d = norm_size(req_size_i);
    acc_lo_d   = req_addr_i[1:0];
    if (acc_size_d == SZ_HALF) begin
      acc_lo_d[0] = 1'b0;
    end else if (acc_size_d == SZ_WORD) begin
      acc_lo_d = 2'b00;
    end
    reject_d = (req_lr_i && req_we_i) || (req_sc_i && !req_we_i) ||
               (req_addr_i[31:2] == '0);
`ifdef DBUS_MISALIGN_TRAP_EN
    if (acc_lo_d != req_addr_i[1:0]) begin
      reject_d = 1'b1;
    end
`endif
  end

  // One aligner serves both directions: store steering is only needed at
  // acceptance (IDLE), load extraction only against the latched request.
  assign al_size = (state_q == ST_IDLE) ? acc_size_d : acc_size_q;
  assign al_lo   = (state_q == ST_IDLE) ? acc_lo_d   : acc_lo_q;

  dbus_lane_align u_align (
    .size_i     (al_size),
    .lo_i       (al_lo),
    .wdata_i    (req_wdata_i),
    .rdata_i    (dbus_rdata_i),
    .unsigned_i (acc_uns_q),
    .wdata_o    (al_wdata),
    .wstrb_o    (al_wstrb),
    .rdata_o    (al_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      lr_q         <= 1'b0;
      sc_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      acc_we_q     <= 1'b0;
      acc_sc_q     <= 1'b0;
      acc_uns_q    <= 1'b0;
      acc_size_q   <= '0;
      acc_lo_q     <= '0;
      cnt_q        <= '0;
    end else begin
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      re_q         <= 1'b0;
      we_q         <= 1'b0;
      lr_q         <= 1'b0;
      sc_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i && ready_q) begin
            acc_we_q   <= req_we_i;
            acc_sc_q   <= req_sc_i;
            acc_uns_q  <= req_unsigned_i;
            acc_size_q <= acc_size_d;
            acc_lo_q   <= acc_lo_d;
            if (reject_d) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q <= ST_ISSUE;
              re_q    <= ~req_we_i;
              we_q    <= req_we_i;
              lr_q    <= req_lr_i;
              sc_q    <= req_sc_i;
              addr_q  <= {req_addr_i[31:2], 2'b00};
              wdata_q <= req_we_i ? al_wdata : '0;
              wstrb_q <= req_we_i ? al_wstrb : '0;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        ST_ISSUE: begin
          state_q <= ST_WAIT;
          cnt_q   <= '0;
        end
        ST_WAIT: begin
          if (!dbus_stall_i) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_rdata_q <= acc_sc_q ? dbus_rdata_i : (acc_we_q ? '0 : al_rdata);
          end else if (TIMEOUT_CYCLES != 0 && (cnt_q + 32'd1) == TIMEOUT_CYCLES) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign dbus_re_o    = re_q;
  assign dbus_we_o    = we_q;
  assign dbus_is_lr_o = lr_q;
  assign dbus_is_sc_o = sc_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_wdata_o = wdata_q;
  assign dbus_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_dbus_initiator.sv
// Directed, table-driven bench for dbus_initiator (TIMEOUT_CYCLES=4).
module tb_dbus_initiator;
  import dbus_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_we_i = 1'b0, req_lr_i = 1'b0, req_sc_i = 1'b0, req_unsigned_i = 1'b0;
  logic [1:0]  req_size_i = 2'b00;
  logic [31:0] req_addr_i = '0, req_wdata_i = '0;
  logic        resp_valid_o, resp_err_o;
  logic [31:0] resp_rdata_o;
  logic        dbus_re_o, dbus_we_o, dbus_is_lr_o, dbus_is_sc_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o;
  logic [3:0]  dbus_wstrb_o;
  logic [31:0] dbus_rdata_i = '0;
  logic        dbus_stall_i = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  dbus_initiator #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .req_valid_i    (req_valid_i),
    .req_ready_o    (req_ready_o),
    .req_we_i       (req_we_i),
    .req_lr_i       (req_lr_i),
    .req_sc_i       (req_sc_i),
    .req_unsigned_i (req_unsigned_i),
    .req_size_i     (req_size_i),
    .req_addr_i     (req_addr_i),
    .req_wdata_i    (req_wdata_i),
    .resp_valid_o   (resp_valid_o),
    .resp_err_o     (resp_err_o),
    .resp_rdata_o   (resp_rdata_o),
    .dbus_re_o      (dbus_re_o),
    .dbus_we_o      (dbus_we_o),
    .dbus_is_lr_o   (dbus_is_lr_o),
    .dbus_is_sc_o   (dbus_is_sc_o),
    .dbus_addr_o    (dbus_addr_o),
    .dbus_wdata_o   (dbus_wdata_o),
    .dbus_wstrb_o   (dbus_wstrb_o),
    .dbus_rdata_i   (dbus_rdata_i),
    .dbus_stall_i   (dbus_stall_i)
  );

  typedef struct {
    logic        we, lr, sc, uns;
    logic [1:0]  size;
    logic [31:0] addr, wdata, rdata;
    int          stall;
    logic        exp_issue;
    logic [31:0] exp_addr;
    logic [3:0]  exp_strb;
    logic [31:0] exp_wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic bus_active();
    return dbus_re_o | dbus_we_o | dbus_is_lr_o | dbus_is_sc_o |
           (dbus_addr_o != '0) | (dbus_wdata_o != '0) | (dbus_wstrb_o != '0);
  endfunction

  task automatic wait_ready(input string name);
    int n = 0;
    while (!req_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    chk(name, {31'd0, req_ready_o}, 32'd1);
  endtask

  // Accept at the next posedge, then observe 16 cycles; stall is held high
  // from the ISSUE cycle for v.stall WAIT cycles, rdata is inverted while stalled.
  task automatic run_vec(input int idx, input vec_t v);
    int          issue_k, n_issue, n_resp, lat;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_strb;
    logic        a_re, a_we, a_lr, a_sc, a_err;
    issue_k = -1; n_issue = 0; n_resp = 0; lat = -1;
    a_addr = '0; a_wdata = '0; a_rdata = '0; a_strb = '0;
    a_re = 0; a_we = 0; a_lr = 0; a_sc = 0; a_err = 0;
    wait_ready($sformatf("v%0d_ready", idx));
    req_we_i = v.we; req_lr_i = v.lr; req_sc_i = v.sc; req_unsigned_i = v.uns;
    req_size_i = v.size; req_addr_i = v.addr; req_wdata_i = v.wdata;
    req_valid_i = 1'b1;
    dbus_stall_i = 1'b0; dbus_rdata_i = v.rdata;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_addr_i = '0; req_wdata_i = '0;
    for (int k = 1; k <= 16; k++) begin
      if (k == 1) chk($sformatf("v%0d_busy_ready", idx), {31'd0, req_ready_o}, 32'd0);
      if (bus_active()) begin
        n_issue++;
        issue_k = k;
        a_addr = dbus_addr_o; a_wdata = dbus_wdata_o; a_strb = dbus_wstrb_o;
        a_re = dbus_re_o; a_we = dbus_we_o; a_lr = dbus_is_lr_o; a_sc = dbus_is_sc_o;
      end
      if (resp_valid_o) begin
        n_resp++;
        lat = k;
        a_err = resp_err_o;
        a_rdata = resp_rdata_o;
      end
      dbus_stall_i = (issue_k > 0) && (v.stall > 0) && (k - issue_k < v.stall + 1);
      dbus_rdata_i = dbus_stall_i ? ~v.rdata : v.rdata;
      @(negedge clk_i);
    end
    dbus_stall_i = 1'b0;
    chk($sformatf("v%0d_issue_count", idx), n_issue, {31'd0, v.exp_issue});
    if (v.exp_issue) begin
      chk($sformatf("v%0d_addr", idx), a_addr, v.exp_addr);
      chk($sformatf("v%0d_wstrb", idx), {28'd0, a_strb}, {28'd0, v.exp_strb});
      chk($sformatf("v%0d_wdata", idx), a_wdata, v.exp_wdata);
      chk($sformatf("v%0d_ctl", idx), {28'd0, a_re, a_we, a_lr, a_sc},
          {28'd0, ~v.we, v.we, v.lr, v.sc});
    end
    chk($sformatf("v%0d_resp_count", idx), n_resp, 32'd1);
    chk($sformatf("v%0d_err", idx), {31'd0, a_err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_rdata", idx), a_rdata, v.exp_rdata);
    chk($sformatf("v%0d_latency", idx), lat, v.exp_lat);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n_resp;
    //          we lr sc un size   addr        wdata         rdata        st iss eaddr     strb     ewdata        err erdata       lat
    vecs[0]  = '{0, 0, 0, 0, 2'b10, 32'h100, 32'h0,        32'hDEADBEEF, 3, 1, 32'h100, 4'h0,    32'h0,        0, 32'hDEADBEEF, 6};
    vecs[1]  = '{1, 0, 0, 0, 2'b00, 32'h203, 32'h123456A5, 32'h0,        0, 1, 32'h200, 4'b1000, 32'hA5A5A5A5, 0, 32'h0,        3};
    vecs[2]  = '{0, 0, 0, 0, 2'b00, 32'h102, 32'h0,        32'h00800000, 1, 1, 32'h100, 4'h0,    32'h0,        0, 32'hFFFFFF80, 4};
    vecs[3]  = '{0, 0, 0, 1, 2'b00, 32'h102, 32'h0,        32'h00800000, 0, 1, 32'h100, 4'h0,    32'h0,        0, 32'h00000080, 3};
    vecs[4]  = '{0, 1, 0, 0, 2'b10, 32'h300, 32'h0,        32'h12345678, 0, 1, 32'h300, 4'h0,    32'h0,        0, 32'h12345678, 3};
    vecs[5]  = '{1, 0, 1, 0, 2'b10, 32'h300, 32'hCAFEF00D, SC_SUCCESS,   2, 1, 32'h300, 4'hF,    32'hCAFEF00D, 0, SC_SUCCESS,   5};
    vecs[6]  = '{1, 0, 1, 0, 2'b10, 32'h300, 32'h0BADCAFE, SC_FAIL,      0, 1, 32'h300, 4'hF,    32'h0BADCAFE, 0, SC_FAIL,      3};
    vecs[7]  = '{0, 0, 0, 0, 2'b10, 32'h400, 32'h0,        32'h55AA55AA, 15,1, 32'h400, 4'h0,    32'h0,        1, 32'h0,        6};
    vecs[8]  = '{0, 0, 0, 0, 2'b10, 32'h000, 32'h0,        32'h11111111, 0, 0, 32'h0,   4'h0,    32'h0,        1, 32'h0,        1};
    vecs[9]  = '{1, 0, 0, 0, 2'b00, 32'h003, 32'h11,       32'h0,        0, 0, 32'h0,   4'h0,    32'h0,        1, 32'h0,        1};
    vecs[10] = '{1, 1, 0, 0, 2'b10, 32'h300, 32'h22,       32'h0,        0, 0, 32'h0,   4'h0,    32'h0,        1, 32'h0,        1};
    vecs[11] = '{0, 0, 1, 0, 2'b10, 32'h300, 32'h0,        32'h0,        0, 0, 32'h0,   4'h0,    32'h0,        1, 32'h0,        1};
`ifdef DBUS_MISALIGN_TRAP_EN
    vecs[12] = '{0, 0, 0, 0, 2'b01, 32'h101, 32'h0,        32'h12348001, 0, 0, 32'h0,   4'h0,    32'h0,        1, 32'h0,        1};
    vecs[17] = '{1, 0, 0, 0, 2'b10, 32'h503, 32'h89ABCDEF, 32'h0,        0, 0, 32'h0,   4'h0,    32'h0,        1, 32'h0,        1};
`else
    vecs[12] = '{0, 0, 0, 0, 2'b01, 32'h101, 32'h0,        32'h12348001, 0, 1, 32'h100, 4'h0,    32'h0,        0, 32'hFFFF8001, 3};
    vecs[17] = '{1, 0, 0, 0, 2'b10, 32'h503, 32'h89ABCDEF, 32'h0,        0, 1, 32'h500, 4'hF,    32'h89ABCDEF, 0, 32'h0,        3};
`endif
    vecs[13] = '{1, 0, 0, 0, 2'b01, 32'h302, 32'hFFFF1236, 32'h0,        0, 1, 32'h300, 4'b1100, 32'h12361236, 0, 32'h0,        3};
    vecs[14] = '{0, 0, 0, 0, 2'b11, 32'h104, 32'h0,        32'h80000000, 0, 1, 32'h104, 4'h0,    32'h0,        0, 32'h80000000, 3};
    vecs[15] = '{0, 0, 0, 1, 2'b01, 32'h106, 32'h0,        32'hBEEF0000, 0, 1, 32'h104, 4'h0,    32'h0,        0, 32'h0000BEEF, 3};
    vecs[16] = '{0, 0, 0, 0, 2'b01, 32'h106, 32'h0,        32'h7FFF0000, 0, 1, 32'h104, 4'h0,    32'h0,        0, 32'h00007FFF, 3};
    vecs[18] = '{0, 0, 0, 0, 2'b00, 32'h201, 32'h0,        32'h0000FE00, 0, 1, 32'h200, 4'h0,    32'h0,        0, 32'hFFFFFFFE, 3};

    // Reset state, then ready must appear one edge after release.
    repeat (2) @(negedge clk_i);
    chk("rst_ready", {31'd0, req_ready_o}, 32'd0);
    chk("rst_resp", {30'd0, resp_valid_o, resp_err_o}, 32'd0);
    chk("rst_rdata", resp_rdata_o, 32'd0);
    chk("rst_bus_active", {31'd0, bus_active()}, 32'd0);
    rst_ni = 1'b1;
    chk("rst_release_ready_low", {31'd0, req_ready_o}, 32'd0);
    @(negedge clk_i);
    chk("rst_release_ready_high", {31'd0, req_ready_o}, 32'd1);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Reset during ISSUE: bus controls drop immediately, no response afterwards.
    wait_ready("mid_ready");
    req_we_i = 1'b0; req_lr_i = 1'b0; req_sc_i = 1'b0; req_unsigned_i = 1'b0;
    req_size_i = SZ_WORD; req_addr_i = 32'h600; req_valid_i = 1'b1;
    @(negedge clk_i);
    req_valid_i = 1'b0;
    dbus_stall_i = 1'b1;
    chk("mid_issue_re", {31'd0, dbus_re_o}, 32'd1);
    chk("mid_issue_addr", dbus_addr_o, 32'h600);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_re", {31'd0, dbus_re_o}, 32'd0);
    chk("mid_rst_addr", dbus_addr_o, 32'd0);
    chk("mid_rst_ready", {31'd0, req_ready_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    dbus_stall_i = 1'b0;
    n_resp = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      if (resp_valid_o) n_resp++;
    end
    chk("mid_rst_no_resp", n_resp, 32'd0);
    chk("mid_rst_ready_back", {31'd0, req_ready_o}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
